// File: rtl/gf12_pad_pkg.sv
// Shared types and constants for the GF12 pad bank controller.
package gf12_pad_pkg;

   // Field order mirrors the cfg_wdata layout: [3] ie_en, [2] sr, [1:0] ds.
   typedef struct packed {
      logic       ie_en;
      logic       sr;
      logic [1:0] ds;
   } pad_cfg_t;

   typedef enum logic [1:0] {
      INPUT = 2'd0,
      TURN  = 2'd1,
      DRIVE = 2'd2
   } pad_state_t;

   localparam int CNT_W = 4;

   localparam pad_cfg_t PAD_CFG_RST = '{ie_en: 1'b1, sr: 1'b0, ds: 2'b01};

   // Reinterpret a raw 4-bit config word as the structured config.
   function automatic pad_cfg_t to_pad_cfg(input logic [3:0] raw);
      pad_cfg_t c;
      c = pad_cfg_t'(raw);
      return c;
   endfunction

endpackage

// File: rtl/gf12_pad_chan.sv
// One pad channel: direction FSM with break-before-make turnaround,
// config register, output data register and input synchroniser.
module gf12_pad_chan
   import gf12_pad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYCLES = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     cfg_we,
   input  pad_cfg_t cfg_wdata,
   output pad_cfg_t cfg,
   output logic     in_turn,
   input  logic     core_out,
   input  logic     oe_req,
   output logic     oe_ack,
   output logic     core_in,
   output logic     pad_a,
   output logic     pad_oe,
   output logic     pad_ds0,
   output logic     pad_ds1,
   output logic     pad_sr,
   output logic     pad_ie,
   input  logic     pad_y
);

   localparam logic [CNT_W-1:0] TURN_RELOAD = CNT_W'(TURN_CYCLES - 1);

   pad_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tgt_q, tgt_d;
   pad_cfg_t         cfg_q;
   logic             pad_a_q;
   logic             core_in_q;
   // Free-running front of the synchroniser; core_in_q is its gated last stage.
   logic [SYNC_STAGES-2:0] sync_p;

   // FSM state, turnaround counter and target direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INPUT;
         cnt_q   <= '0;
         tgt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next-state logic; pad controls decode straight from the state register
   // so pad_oe drops on the same edge that leaves DRIVE and on async reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      pad_oe  = 1'b0;
      pad_ie  = 1'b0;
      oe_ack  = 1'b0;
      case (state_q)
         INPUT: begin
            pad_ie = cfg_q.ie_en;
            if (oe_req) begin
               tgt_d   = 1'b1;
               cnt_d   = TURN_RELOAD;
               state_d = TURN;
            end
         end
         TURN: begin
            if (oe_req != tgt_q) begin
               // Request changed mid-turnaround: restart the full dead time.
               tgt_d = oe_req;
               cnt_d = TURN_RELOAD;
            end else if (cnt_q == '0) begin
               state_d = tgt_q ? DRIVE : INPUT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DRIVE: begin
            pad_oe = 1'b1;
            oe_ack = 1'b1;
            if (!oe_req) begin
               tgt_d   = 1'b0;
               cnt_d   = TURN_RELOAD;
               state_d = TURN;
            end
         end
         default: begin
            state_d = INPUT;
         end
      endcase
   end

   // Per-pad drive/slew/input-enable configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q <= PAD_CFG_RST;
      end else if (cfg_we) begin
         cfg_q <= cfg_wdata;
      end
   end

   // Output data register, updated regardless of direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_a_q <= 1'b0;
      end else begin
         pad_a_q <= core_out;
      end
   end

   // Input synchroniser; the last stage only advances while listening.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p    <= '0;
         core_in_q <= 1'b0;
      end else begin
         sync_p[0] <= pad_y;
         for (int i = 1; i < SYNC_STAGES - 1; i++) begin
            sync_p[i] <= sync_p[i-1];
         end
         if (state_q == INPUT && cfg_q.ie_en) begin
            core_in_q <= sync_p[SYNC_STAGES-2];
         end
      end
   end

   assign cfg     = cfg_q;
   assign in_turn = (state_q == TURN);
   assign pad_a   = pad_a_q;
   assign core_in = core_in_q;
   assign pad_ds0 = cfg_q.ds[0];
   assign pad_ds1 = cfg_q.ds[1];
   assign pad_sr  = cfg_q.sr;

endmodule

// File: rtl/gf12_pad_bank_ctrl.sv
// Bank of GF12 pad channels with a shared config port.
module gf12_pad_bank_ctrl
   import gf12_pad_pkg::*;
#(
   parameter int NPADS       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYCLES = 2,
   localparam int AW         = (NPADS > 1) ? $clog2(NPADS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [3:0]       cfg_wdata,
   output logic [3:0]       cfg_rdata,
   input  logic [NPADS-1:0] core_out,
   input  logic [NPADS-1:0] core_oe_req,
   output logic [NPADS-1:0] core_oe_ack,
   output logic [NPADS-1:0] core_in,
   output logic [NPADS-1:0] pad_a,
   output logic [NPADS-1:0] pad_oe,
   output logic [NPADS-1:0] pad_ds0,
   output logic [NPADS-1:0] pad_ds1,
   output logic [NPADS-1:0] pad_sr,
   output logic [NPADS-1:0] pad_ie,
   input  logic [NPADS-1:0] pad_y
);

   localparam int NSLOT = 1 << AW;

   logic [NPADS-1:0] cfg_we;
   logic [NPADS-1:0] in_turn;
   pad_cfg_t         pad_cfg [NPADS];

   // Address space padded to a power of two; unused slots read as idle/zero.
   logic [NSLOT-1:0] turn_ext;
   pad_cfg_t         rdata_ext [NSLOT];

   for (genvar i = 0; i < NPADS; i++) begin : g_chan
      gf12_pad_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .TURN_CYCLES (TURN_CYCLES)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .cfg_we    (cfg_we[i]),
         .cfg_wdata (to_pad_cfg(cfg_wdata)),
         .cfg       (pad_cfg[i]),
         .in_turn   (in_turn[i]),
         .core_out  (core_out[i]),
         .oe_req    (core_oe_req[i]),
         .oe_ack    (core_oe_ack[i]),
         .core_in   (core_in[i]),
         .pad_a     (pad_a[i]),
         .pad_oe    (pad_oe[i]),
         .pad_ds0   (pad_ds0[i]),
         .pad_ds1   (pad_ds1[i]),
         .pad_sr    (pad_sr[i]),
         .pad_ie    (pad_ie[i]),
         .pad_y     (pad_y[i])
      );
   end

   for (genvar i = 0; i < NSLOT; i++) begin : g_ext
      if (i < NPADS) begin : g_used
         assign turn_ext[i]  = in_turn[i];
         assign rdata_ext[i] = pad_cfg[i];
      end else begin : g_unused
         assign turn_ext[i]  = 1'b0;
         assign rdata_ext[i] = '0;
      end
   end

   // Config port is stalled only while the addressed pad is turning round.
   always_comb begin
      cfg_ready = ~turn_ext[cfg_addr];
      cfg_rdata = rdata_ext[cfg_addr];
   end

   // Address decode of accepted writes; out-of-range addresses match no pad.
   always_comb begin
      cfg_we = '0;
      for (int i = 0; i < NPADS; i++) begin
         cfg_we[i] = cfg_valid && cfg_ready && (cfg_addr == AW'(i));
      end
   end

endmodule

// File: tb/tb_gf12_pad_bank_ctrl.sv
// Directed testbench for gf12_pad_bank_ctrl (8-pad bank plus a 6-pad bank).
module tb_gf12_pad_bank_ctrl;

   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_addr;
   logic [3:0] cfg_wdata;
   logic [3:0] cfg_rdata;
   logic [7:0] core_out, core_oe_req, core_oe_ack, core_in;
   logic [7:0] pad_a, pad_oe, pad_ds0, pad_ds1, pad_sr, pad_ie, pad_y;

   logic       o_cfg_valid;
   logic       o_cfg_ready;
   logic [2:0] o_cfg_addr;
   logic [3:0] o_cfg_wdata;
   logic [3:0] o_cfg_rdata;
   logic [5:0] o_core_out, o_core_oe_req, o_core_oe_ack, o_core_in;
   logic [5:0] o_pad_a, o_pad_oe, o_pad_ds0, o_pad_ds1, o_pad_sr, o_pad_ie, o_pad_y;

   int checks;
   int errors;

   gf12_pad_bank_ctrl #(.NPADS(8), .SYNC_STAGES(2), .TURN_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .core_out(core_out), .core_oe_req(core_oe_req), .core_oe_ack(core_oe_ack),
      .core_in(core_in), .pad_a(pad_a), .pad_oe(pad_oe), .pad_ds0(pad_ds0),
      .pad_ds1(pad_ds1), .pad_sr(pad_sr), .pad_ie(pad_ie), .pad_y(pad_y)
   );

   gf12_pad_bank_ctrl #(.NPADS(6), .SYNC_STAGES(2), .TURN_CYCLES(2)) u_oor (
      .clk(clk), .rst(rst),
      .cfg_valid(o_cfg_valid), .cfg_ready(o_cfg_ready), .cfg_addr(o_cfg_addr),
      .cfg_wdata(o_cfg_wdata), .cfg_rdata(o_cfg_rdata),
      .core_out(o_core_out), .core_oe_req(o_core_oe_req), .core_oe_ack(o_core_oe_ack),
      .core_in(o_core_in), .pad_a(o_pad_a), .pad_oe(o_pad_oe), .pad_ds0(o_pad_ds0),
      .pad_ds1(o_pad_ds1), .pad_sr(o_pad_sr), .pad_ie(o_pad_ie), .pad_y(o_pad_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [3:0] data);
      cfg_addr  = addr;
      cfg_wdata = data;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checks++; if (pad_oe !== 8'h00) begin errors++; $display("FAIL rst_pad_oe got %h exp %h", pad_oe, 8'h00); end
      checks++; if (pad_ie !== 8'hFF) begin errors++; $display("FAIL rst_pad_ie got %h exp %h", pad_ie, 8'hFF); end
      checks++; if (pad_ds0 !== 8'hFF) begin errors++; $display("FAIL rst_ds0 got %h exp %h", pad_ds0, 8'hFF); end
      checks++; if (pad_ds1 !== 8'h00) begin errors++; $display("FAIL rst_ds1 got %h exp %h", pad_ds1, 8'h00); end
      checks++; if (pad_sr !== 8'h00) begin errors++; $display("FAIL rst_sr got %h exp %h", pad_sr, 8'h00); end
      checks++; if (core_oe_ack !== 8'h00) begin errors++; $display("FAIL rst_ack got %h exp %h", core_oe_ack, 8'h00); end
      checks++; if (core_in !== 8'h00) begin errors++; $display("FAIL rst_core_in got %h exp %h", core_in, 8'h00); end
      checks++; if (pad_a !== 8'h00) begin errors++; $display("FAIL rst_pad_a got %h exp %h", pad_a, 8'h00); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %b exp 1", cfg_ready); end
      cfg_addr = 3'd0;
      #1;
      checks++; if (cfg_rdata !== 4'b1001) begin errors++; $display("FAIL rst_rdata got %b exp 1001", cfg_rdata); end
   endtask

   task automatic test_pad_a();
      core_out = 8'hA5;
      #1;
      checks++; if (pad_a !== 8'h00) begin errors++; $display("FAIL pad_a_hold got %h exp %h", pad_a, 8'h00); end
      tick();
      checks++; if (pad_a !== 8'hA5) begin errors++; $display("FAIL pad_a_upd got %h exp %h", pad_a, 8'hA5); end
      core_out = 8'h3C;
      tick();
      checks++; if (pad_a !== 8'h3C) begin errors++; $display("FAIL pad_a_upd2 got %h exp %h", pad_a, 8'h3C); end
   endtask

   task automatic test_turnaround();
      // Cycle t: request rises.
      core_oe_req[0] = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         checks++; if (pad_oe[0] !== 1'b0) begin errors++; $display("FAIL turn_oe t+%0d got %b exp 0", k, pad_oe[0]); end
         checks++; if (pad_ie[0] !== 1'b0) begin errors++; $display("FAIL turn_ie t+%0d got %b exp 0", k, pad_ie[0]); end
         checks++; if (core_oe_ack[0] !== 1'b0) begin errors++; $display("FAIL turn_ack t+%0d got %b exp 0", k, core_oe_ack[0]); end
      end
      tick();
      checks++; if (pad_oe[0] !== 1'b1) begin errors++; $display("FAIL drive_oe t+3 got %b exp 1", pad_oe[0]); end
      checks++; if (core_oe_ack[0] !== 1'b1) begin errors++; $display("FAIL drive_ack t+3 got %b exp 1", core_oe_ack[0]); end
      checks++; if (pad_ie[0] !== 1'b0) begin errors++; $display("FAIL drive_ie t+3 got %b exp 0", pad_ie[0]); end
      repeat (7) tick();
      checks++; if (pad_oe[0] !== 1'b1) begin errors++; $display("FAIL drive_oe t+10 got %b exp 1", pad_oe[0]); end
      // Cycle t+10: request drops.
      core_oe_req[0] = 1'b0;
      tick();
      checks++; if (pad_oe[0] !== 1'b0) begin errors++; $display("FAIL release_oe t+11 got %b exp 0", pad_oe[0]); end
      checks++; if (pad_ie[0] !== 1'b0) begin errors++; $display("FAIL release_ie t+11 got %b exp 0", pad_ie[0]); end
      tick();
      checks++; if (pad_ie[0] !== 1'b0) begin errors++; $display("FAIL release_ie t+12 got %b exp 0", pad_ie[0]); end
      tick();
      checks++; if (pad_ie[0] !== 1'b1) begin errors++; $display("FAIL release_ie t+13 got %b exp 1", pad_ie[0]); end
      checks++; if (pad_oe[0] !== 1'b0) begin errors++; $display("FAIL release_oe t+13 got %b exp 0", pad_oe[0]); end
   endtask

   task automatic test_abort();
      logic [3:0] exp_ie;
      exp_ie = 4'b1000;  // ie at t+1..t+4: TURN, TURN, TURN, INPUT
      core_oe_req[1] = 1'b1;
      tick();
      // In TURN with counter 1: request withdrawn.
      core_oe_req[1] = 1'b0;
      checks++; if (pad_ie[1] !== exp_ie[0]) begin errors++; $display("FAIL abort_ie t+1 got %b exp %b", pad_ie[1], exp_ie[0]); end
      for (int k = 2; k <= 4; k++) begin
         tick();
         checks++; if (pad_ie[1] !== exp_ie[k-1]) begin errors++; $display("FAIL abort_ie t+%0d got %b exp %b", k, pad_ie[1], exp_ie[k-1]); end
         checks++; if (pad_oe[1] !== 1'b0) begin errors++; $display("FAIL abort_oe t+%0d got %b exp 0", k, pad_oe[1]); end
      end
      tick();
      checks++; if (pad_oe[1] !== 1'b0) begin errors++; $display("FAIL abort_oe_after got %b exp 0", pad_oe[1]); end
   endtask

   task automatic test_config();
      cfg_write(3'd5, 4'b0110);
      checks++; if (pad_ds1[5] !== 1'b1) begin errors++; $display("FAIL cfg_ds1 got %b exp 1", pad_ds1[5]); end
      checks++; if (pad_ds0[5] !== 1'b0) begin errors++; $display("FAIL cfg_ds0 got %b exp 0", pad_ds0[5]); end
      checks++; if (pad_sr[5] !== 1'b1) begin errors++; $display("FAIL cfg_sr got %b exp 1", pad_sr[5]); end
      checks++; if (pad_ie[5] !== 1'b0) begin errors++; $display("FAIL cfg_ie got %b exp 0", pad_ie[5]); end
      checks++; if (cfg_rdata !== 4'b0110) begin errors++; $display("FAIL cfg_rdata got %b exp 0110", cfg_rdata); end
      checks++; if (pad_ds0 !== 8'hDF) begin errors++; $display("FAIL cfg_ds0_others got %h exp %h", pad_ds0, 8'hDF); end
      // Write while the pad turns round: stalled until it reaches DRIVE.
      core_oe_req[5] = 1'b1;
      tick();
      cfg_addr  = 3'd5;
      cfg_wdata = 4'b1011;
      cfg_valid = 1'b1;
      #1;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready t+1 got %b exp 0", cfg_ready); end
      tick();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready t+2 got %b exp 0", cfg_ready); end
      checks++; if (cfg_rdata !== 4'b0110) begin errors++; $display("FAIL busy_hold got %b exp 0110", cfg_rdata); end
      tick();
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL busy_ready t+3 got %b exp 1", cfg_ready); end
      checks++; if (pad_oe[5] !== 1'b1) begin errors++; $display("FAIL busy_oe got %b exp 1", pad_oe[5]); end
      tick();
      cfg_valid = 1'b0;
      checks++; if (cfg_rdata !== 4'b1011) begin errors++; $display("FAIL busy_write got %b exp 1011", cfg_rdata); end
      checks++; if (pad_ds0[5] !== 1'b1 || pad_ds1[5] !== 1'b1) begin errors++; $display("FAIL busy_ds got %b%b exp 11", pad_ds1[5], pad_ds0[5]); end
      core_oe_req[5] = 1'b0;
      repeat (4) tick();
      checks++; if (pad_ie[5] !== 1'b1) begin errors++; $display("FAIL busy_ie_back got %b exp 1", pad_ie[5]); end
   endtask

   task automatic test_sync();
      #2 pad_y[2] = 1'b1;
      tick();
      checks++; if (core_in[2] !== 1'b0) begin errors++; $display("FAIL sync_rise_1 got %b exp 0", core_in[2]); end
      tick();
      checks++; if (core_in[2] !== 1'b1) begin errors++; $display("FAIL sync_rise_2 got %b exp 1", core_in[2]); end
      #3 pad_y[2] = 1'b0;
      tick();
      checks++; if (core_in[2] !== 1'b1) begin errors++; $display("FAIL sync_fall_1 got %b exp 1", core_in[2]); end
      tick();
      checks++; if (core_in[2] !== 1'b0) begin errors++; $display("FAIL sync_fall_2 got %b exp 0", core_in[2]); end
      pad_y[2] = 1'b1;
      repeat (3) tick();
      checks++; if (core_in[2] !== 1'b1) begin errors++; $display("FAIL sync_rise_3 got %b exp 1", core_in[2]); end
      // Input disabled: core_in freezes.
      cfg_write(3'd2, 4'b0001);
      checks++; if (pad_ie[2] !== 1'b0) begin errors++; $display("FAIL sync_ie_off got %b exp 0", pad_ie[2]); end
      pad_y[2] = 1'b0;
      repeat (4) tick();
      checks++; if (core_in[2] !== 1'b1) begin errors++; $display("FAIL sync_hold got %b exp 1", core_in[2]); end
   endtask

   task automatic test_out_of_range();
      o_cfg_addr = 3'd7;
      #1;
      checks++; if (o_cfg_rdata !== 4'b0000) begin errors++; $display("FAIL oor_rdata_pre got %b exp 0000", o_cfg_rdata); end
      checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got %b exp 1", o_cfg_ready); end
      o_cfg_wdata = 4'b0110;
      o_cfg_valid = 1'b1;
      tick();
      o_cfg_valid = 1'b0;
      checks++; if (o_cfg_rdata !== 4'b0000) begin errors++; $display("FAIL oor_rdata got %b exp 0000", o_cfg_rdata); end
      checks++; if (o_pad_ds0 !== 6'h3F || o_pad_ds1 !== 6'h00 || o_pad_sr !== 6'h00 || o_pad_ie !== 6'h3F)
         begin errors++; $display("FAIL oor_cfg got ds0=%h ds1=%h sr=%h ie=%h exp 3f 00 00 3f", o_pad_ds0, o_pad_ds1, o_pad_sr, o_pad_ie); end
      o_cfg_addr = 3'd4;
      #1;
      checks++; if (o_cfg_rdata !== 4'b1001) begin errors++; $display("FAIL oor_rdata_pad4 got %b exp 1001", o_cfg_rdata); end
   endtask

   task automatic test_reset_mid_drive();
      core_oe_req[3] = 1'b1;
      repeat (3) tick();
      checks++; if (pad_oe[3] !== 1'b1) begin errors++; $display("FAIL mid_pre_oe got %b exp 1", pad_oe[3]); end
      #2 rst = 1'b1;
      #1;
      checks++; if (pad_oe !== 8'h00) begin errors++; $display("FAIL mid_async_oe got %h exp %h", pad_oe, 8'h00); end
      checks++; if (pad_ie !== 8'hFF) begin errors++; $display("FAIL mid_pad_ie got %h exp %h", pad_ie, 8'hFF); end
      checks++; if (pad_ds0 !== 8'hFF) begin errors++; $display("FAIL mid_ds0 got %h exp %h", pad_ds0, 8'hFF); end
      checks++; if (pad_ds1 !== 8'h00) begin errors++; $display("FAIL mid_ds1 got %h exp %h", pad_ds1, 8'h00); end
      checks++; if (core_oe_ack !== 8'h00) begin errors++; $display("FAIL mid_ack got %h exp %h", core_oe_ack, 8'h00); end
      core_oe_req = 8'h00;
      tick();
      rst = 1'b0;
      tick();
      checks++; if (pad_oe !== 8'h00) begin errors++; $display("FAIL mid_post_oe got %h exp %h", pad_oe, 8'h00); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_addr    = '0;
      cfg_wdata   = '0;
      core_out    = '0;
      core_oe_req = '0;
      pad_y       = '0;
      o_cfg_valid = 1'b0;
      o_cfg_addr  = '0;
      o_cfg_wdata = '0;
      o_core_out  = '0;
      o_core_oe_req = '0;
      o_pad_y     = '0;

      test_reset();
      test_pad_a();
      test_turnaround();
      test_abort();
      test_config();
      test_sync();
      test_out_of_range();
      test_reset_mid_drive();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf12_pad_bank_ctrl.md
Name: gf12_pad_bank_ctrl

Overview:
Sequenced controller for a bank of NPADS GF12 bidirectional pads.
- Sits between core logic and the pad-cell instances, driving A/OE/DS0/DS1/SR/IE on each pad and taking Y back.
- Holds per-pad drive/slew/input-enable configuration, written through a valid/ready port.
- Enforces break-before-make direction turnaround.
- Synchronises pad inputs into the clk domain.

Parameters:
- NPADS, 8: number of pads in the bank (1..32).
- SYNC_STAGES, 2: flops in each pad-input synchroniser (2..4).
- TURN_CYCLES, 2: cycles with both OE and IE low during a direction change (1..15).

Ports:
- clk  in  1  bank clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid&ready.
- cfg_addr  in  $clog2(NPADS) (min 1)  target pad index.
- cfg_wdata  in  4  [1:0] ds, [2] sr, [3] ie_en.
- cfg_rdata  out  4  config of pad cfg_addr, combinational.
- core_out  in  NPADS  data to drive.
- core_oe_req  in  NPADS  per-pad request to drive.
- core_oe_ack  out  NPADS  pad is driving.
- core_in  out  NPADS  synchronised pad input.
- pad_a  out  NPADS  to pad A.
- pad_oe  out  NPADS  to pad OE.
- pad_ds0  out  NPADS  to pad DS0.
- pad_ds1  out  NPADS  to pad DS1.
- pad_sr  out  NPADS  to pad SR.
- pad_ie  out  NPADS  to pad IE.
- pad_y  in  NPADS  from pad Y, asynchronous.

Behaviour:
Reset (async assert, sync release) puts every pad in this state:
- state INPUT; ds=2'b01, sr=0, ie_en=1.
- pad_oe=0, pad_a=0, pad_ie=1, core_oe_ack=0, core_in=0, synchronisers cleared.
- cfg_ready=1.

Per-pad FSM (independent per pad), states INPUT, TURN, DRIVE; a 4-bit counter and a target bit per pad:
- INPUT: pad_oe=0, pad_ie=ie_en, ack=0. When core_oe_req=1: target=1, counter=TURN_CYCLES-1, next state TURN.
- TURN: pad_oe=0, pad_ie=0, ack=0. Counter decrements each cycle.
  - At counter 0: target=1 goes to DRIVE, target=0 goes to INPUT.
  - If core_oe_req differs from target during TURN: target takes the new value and the counter reloads TURN_CYCLES-1.
- DRIVE: pad_oe=1, pad_ie=0, ack=1. When core_oe_req=0: target=0, counter reload, next state TURN. pad_oe falls in that same transition, so there is no OE-high cycle after the request drops.
- Latency: req rise to pad_oe=1 and ack=1 is TURN_CYCLES+1 cycles. DRIVE to INPUT also takes TURN_CYCLES+1 cycles.

Datapath outputs:
- pad_a is registered core_out: 1-cycle latency, updated in every state.
- pad_ds0, pad_ds1 and pad_sr are registered config bits; they change the cycle after the write.

Config port:
- cfg_ready = 0 while the pad at cfg_addr is in TURN, 1 otherwise.
- A write accepted in a cycle where that pad's FSM also transitions is applied normally. The ie_en change takes effect only in INPUT.
- Out-of-range cfg_addr (>= NPADS): write is accepted and ignored; cfg_rdata=0.

Input path:
- Synchroniser samples pad_y every cycle. core_in = last synchroniser stage, updated only while the pad is in INPUT with ie_en=1. Otherwise it holds its last value.
- Latency from a pad_y edge to core_in is SYNC_STAGES cycles.

Reset mid-operation: any state returns to INPUT immediately; pad_oe drops asynchronously.

Decomposition:
- Package gf12_pad_pkg:
  - typedef pad_cfg_t {ds[1:0], sr, ie_en}.
  - enum pad_state_t {INPUT, TURN, DRIVE}.
  - constant PAD_CFG_RST = '{2'b01, 0, 1}.
- Sub-module gf12_pad_chan: one-pad FSM, counter, config register, synchroniser. Instantiated NPADS times via generate.
- Top level holds only address decode, cfg_ready mux and cfg_rdata mux.

Test Plan:
- Reset: assert rst mid-DRIVE on pad 3. Expect pad_oe=0 asynchronously, pad_ie=8'hFF, ds0=8'hFF, ds1=0, ack=0.
- Turnaround with TURN_CYCLES=2: raise core_oe_req[0] at cycle t.
  - Expect pad_oe[0]=0 and pad_ie[0]=0 at t+1..t+2, pad_oe[0]=1 and ack[0]=1 at t+3.
  - Drop req at t+10: pad_oe[0]=0 at t+11, pad_ie[0]=1 at t+13.
- Abort: req[1] rises, falls at TURN counter 1. Expect counter reload, return to INPUT after 2 more TURN cycles, pad_oe[1] never 1.
- Config: write pad 5 with wdata 4'b0110 (ds=2'b10, sr=1, ie_en=0).
  - Expect ds1[5]=1, ds0[5]=0, sr[5]=1 next cycle; pad_ie[5]=0; cfg_rdata=4'b0110 at addr 5.
  - Writing to a pad in TURN holds cfg_ready=0 until the pad exits TURN.
- Sync: toggle pad_y[2] asynchronously with SYNC_STAGES=2. Expect core_in[2] to follow after 2 cycles. With ie_en[2]=0, core_in[2] holds its value.
- Out-of-range: NPADS=6, write addr 7. Expect accept, no config change, cfg_rdata=0.
